// File: rtl/sudoku_game_fsm_if.sv
// Button/board bundle between the front-end and sudoku_game_fsm.
// master drives buttons, tick and puzzle; slave returns game status.
interface sudoku_game_fsm_if #(
  parameter int SIDE = 9,
  parameter int VW   = 4,
  parameter int TW   = 11
);
  logic                     tick_1hz;
  logic                     up_button;
  logic                     down_button;
  logic                     left_button;
  logic                     right_button;
  logic                     start_button;
  logic                     a_button;
  logic                     b_button;
  logic [SIDE*SIDE-1:0]     selected_visibility;
  logic [SIDE*SIDE*VW-1:0]  selected_map;
  logic [2:0]               state;
  logic [VW-1:0]            pos_i;
  logic [VW-1:0]            pos_j;
  logic [VW-1:0]            cell_value;
  logic [VW-1:0]            selected_number;
  logic [1:0]               strikes;
  logic [TW-1:0]            elapsed;
  logic                     difficulty;
  logic                     playing_condition;
  logic                     error;

  modport master (
    output tick_1hz, up_button, down_button, left_button,
    output right_button, start_button, a_button, b_button,
    output selected_visibility, selected_map,
    input  state, pos_i, pos_j, cell_value, selected_number,
    input  strikes, elapsed, difficulty, playing_condition, error
  );

  modport slave (
    input  tick_1hz, up_button, down_button, left_button,
    input  right_button, start_button, a_button, b_button,
    input  selected_visibility, selected_map,
    output state, pos_i, pos_j, cell_value, selected_number,
    output strikes, elapsed, difficulty, playing_condition, error
  );
endinterface

// File: rtl/sudoku_game_fsm.sv
// Sudoku game controller: FSM, cursor, board, strikes, play timer.
// Ports: clk, reset (async low), bus (slave); pause via SUDOKU_PAUSE_EN.
module sudoku_game_fsm #(
  parameter int SIDE        = 9,
  parameter int VW          = 4,
  parameter int MAX_STRIKES = 3,
  parameter int TIME_LIMIT  = 600,
  parameter int TW          = 11
) (
  input  logic               clk,
  input  logic               reset,
  sudoku_game_fsm_if.slave   bus
);
  localparam int N  = SIDE * SIDE;
  localparam int IW = $clog2(N);
  localparam logic [VW-1:0] LAST = VW'(SIDE - 1);
  localparam logic [VW-1:0] TOP  = VW'(SIDE);
  localparam logic [VW-1:0] ONE  = VW'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    SELECT   = 3'b001,
    LOAD     = 3'b010,
    NAVIGATE = 3'b011,
    ENTER    = 3'b100,
    VICTORY  = 3'b101,
    DEFEAT   = 3'b110,
    PAUSE    = 3'b111
  } state_t;

  state_t            state_q;
  logic [VW-1:0]     pi_q, pj_q, sel_q;
  logic [1:0]        str_q;
  logic [TW-1:0]     el_q;
  logic              diff_q, err_q;
  logic [N-1:0]      vis_q;
  logic [VW-1:0]     brd_q [N];
  logic [6:0]        btn_q;
`ifdef SUDOKU_PAUSE_EN
  state_t            ret_q;
`endif

  logic [6:0]    btn, prs;
  logic          p_up, p_dn, p_lf, p_rt, p_st, p_a, p_b;
  logic [IW-1:0] idx;
  logic [TW-1:0] lim;
  logic          play, lose, win;

  assign btn = {bus.b_button, bus.a_button, bus.start_button,
                bus.right_button, bus.left_button,
                bus.down_button, bus.up_button};
  assign prs  = btn & ~btn_q;
  assign p_up = prs[0];
  assign p_dn = prs[1];
  assign p_lf = prs[2];
  assign p_rt = prs[3];
  assign p_st = prs[4];
  assign p_a  = prs[5];
  assign p_b  = prs[6];

  assign idx  = IW'(int'(pi_q) * SIDE + int'(pj_q));
  assign lim  = diff_q ? TW'(TIME_LIMIT / 2) : TW'(TIME_LIMIT);
  assign play = (state_q == NAVIGATE) || (state_q == ENTER);
  // Checked on registered values, so a game-ending update shows
  // for one cycle before the terminal state is entered.
  assign lose = (str_q == 2'(MAX_STRIKES)) || (el_q == lim);
  assign win  = &vis_q;

  assign bus.state             = state_q;
  assign bus.pos_i             = pi_q;
  assign bus.pos_j             = pj_q;
  assign bus.cell_value        = vis_q[idx] ? brd_q[idx] : '0;
  assign bus.selected_number   = sel_q;
  assign bus.strikes           = str_q;
  assign bus.elapsed           = el_q;
  assign bus.difficulty        = diff_q;
  assign bus.playing_condition = play;
  assign bus.error             = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pi_q    <= '0;
      pj_q    <= '0;
      sel_q   <= ONE;
      str_q   <= '0;
      el_q    <= '0;
      diff_q  <= 1'b0;
      err_q   <= 1'b0;
      vis_q   <= '0;
      btn_q   <= '0;
      for (int k = 0; k < N; k++) brd_q[k] <= '0;
`ifdef SUDOKU_PAUSE_EN
      ret_q   <= IDLE;
`endif
    end else begin
      btn_q <= btn;
      err_q <= 1'b0;
      if (play && bus.tick_1hz && el_q != lim)
        el_q <= el_q + TW'(1);
      unique case (state_q)
        IDLE: if (p_st) state_q <= SELECT;
        SELECT: begin
          if (p_up)      diff_q <= 1'b1;
          else if (p_dn) diff_q <= 1'b0;
          if (p_a) state_q <= LOAD;
        end
        LOAD: begin
          vis_q <= bus.selected_visibility;
          for (int k = 0; k < N; k++)
            brd_q[k] <= bus.selected_map[k*VW +: VW];
          pi_q  <= '0;
          pj_q  <= '0;
          str_q <= '0;
          el_q  <= '0;
          sel_q <= ONE;
          if (p_st) state_q <= NAVIGATE;
        end
        NAVIGATE: begin
          if (lose)     state_q <= DEFEAT;
          else if (win) state_q <= VICTORY;
`ifdef SUDOKU_PAUSE_EN
          else if (p_st) begin
            ret_q   <= NAVIGATE;
            state_q <= PAUSE;
          end
`endif
          else begin
            if (p_up)      pi_q <= (pi_q == '0) ? LAST : pi_q - ONE;
            else if (p_dn) pi_q <= (pi_q == LAST) ? '0 : pi_q + ONE;
            else if (p_lf) pj_q <= (pj_q == '0) ? LAST : pj_q - ONE;
            else if (p_rt) pj_q <= (pj_q == LAST) ? '0 : pj_q + ONE;
            if (p_a && !vis_q[idx]) state_q <= ENTER;
          end
        end
        ENTER: begin
          if (lose)     state_q <= DEFEAT;
          else if (win) state_q <= VICTORY;
`ifdef SUDOKU_PAUSE_EN
          else if (p_st) begin
            ret_q   <= ENTER;
            state_q <= PAUSE;
          end
`endif
          else if (p_a) begin
            if (brd_q[idx] == sel_q) begin
              vis_q[idx] <= 1'b1;
              state_q    <= NAVIGATE;
            end else begin
              if (str_q != 2'd3) str_q <= str_q + 2'd1;
              err_q <= 1'b1;
            end
          end
          else if (p_b)  state_q <= NAVIGATE;
          else if (p_up) sel_q <= (sel_q == TOP) ? ONE : sel_q + ONE;
          else if (p_dn) sel_q <= (sel_q == ONE) ? TOP : sel_q - ONE;
        end
        VICTORY, DEFEAT: if (p_st) state_q <= SELECT;
        PAUSE: begin
`ifdef SUDOKU_PAUSE_EN
          if (lose)      state_q <= DEFEAT;
          else if (p_st) state_q <= ret_q;
`else
          state_q <= IDLE;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sudoku_game_fsm.sv
// Scoreboard bench for sudoku_game_fsm, SIDE=4, TIME_LIMIT=4.
// Stimulus queues cycle-tagged expectations; a negedge monitor checks them.
module tb_sudoku_game_fsm;
  localparam int SIDE = 4;
  localparam int VW   = 4;
  localparam int TW   = 11;

  localparam int F_ST = 0, F_PI = 1, F_PJ = 2, F_SEL = 3, F_STR = 4;
  localparam int F_EL = 5, F_ERR = 6, F_CELL = 7, F_PC = 8, F_DIF = 9;
  localparam int B_UP = 0, B_DN = 1, B_LF = 2, B_RT = 3;
  localparam int B_ST = 4, B_A = 5, B_B = 6;

  typedef struct {
    int    due;
    int    fld;
    int    val;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;
  exp_t q[$];
  logic [SIDE*SIDE*VW-1:0] map;

  sudoku_game_fsm_if #(.SIDE(SIDE), .VW(VW), .TW(TW)) bus ();

  sudoku_game_fsm #(
    .SIDE(SIDE), .VW(VW), .MAX_STRIKES(3), .TIME_LIMIT(4), .TW(TW)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int field(int f);
    case (f)
      F_ST:   return int'(bus.state);
      F_PI:   return int'(bus.pos_i);
      F_PJ:   return int'(bus.pos_j);
      F_SEL:  return int'(bus.selected_number);
      F_STR:  return int'(bus.strikes);
      F_EL:   return int'(bus.elapsed);
      F_ERR:  return int'(bus.error);
      F_CELL: return int'(bus.cell_value);
      F_PC:   return int'(bus.playing_condition);
      default: return int'(bus.difficulty);
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      int   act;
      e   = q.pop_front();
      act = field(e.fld);
      tests++;
      if (act !== e.val) begin
        failed++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                 e.name, act, e.val, cyc);
      end
    end
  end

  task automatic expect_v(string n, int f, int v);
    exp_t e;
    e.due  = cyc;
    e.fld  = f;
    e.val  = v;
    e.name = n;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(int b, logic v);
    case (b)
      B_UP: bus.up_button    = v;
      B_DN: bus.down_button  = v;
      B_LF: bus.left_button  = v;
      B_RT: bus.right_button = v;
      B_ST: bus.start_button = v;
      B_A:  bus.a_button     = v;
      default: bus.b_button  = v;
    endcase
  endtask

  task automatic press(int b);
    step();
    set_btn(b, 1'b1);
    step();
    set_btn(b, 1'b0);
  endtask

  task automatic tick();
    bus.tick_1hz = 1'b1;
    step();
    bus.tick_1hz = 1'b0;
  endtask

  task automatic expect_reset(string n);
    expect_v({n, "_state"}, F_ST, 0);
    expect_v({n, "_pi"}, F_PI, 0);
    expect_v({n, "_pj"}, F_PJ, 0);
    expect_v({n, "_sel"}, F_SEL, 1);
    expect_v({n, "_str"}, F_STR, 0);
    expect_v({n, "_el"}, F_EL, 0);
    expect_v({n, "_err"}, F_ERR, 0);
    expect_v({n, "_diff"}, F_DIF, 0);
    expect_v({n, "_pc"}, F_PC, 0);
    expect_v({n, "_cell"}, F_CELL, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < SIDE * SIDE; k++)
      map[k*VW +: VW] = VW'((k % 4) + 1);
    bus.selected_map        = map;
    bus.selected_visibility = 16'hFFFB;
    bus.tick_1hz = 1'b0;
    for (int b = 0; b < 7; b++) set_btn(b, 1'b0);
    repeat (3) step();
    rst_n = 1'b1;
    expect_reset("rst");

    // Game 1: navigation, wrong entries, strike defeat
    press(B_ST); expect_v("idle_start", F_ST, 1);
    tick();      expect_v("sel_tick", F_EL, 0);
    press(B_UP); expect_v("diff_up", F_DIF, 1);
    press(B_DN); expect_v("diff_dn", F_DIF, 0);
    press(B_A);  expect_v("to_load", F_ST, 2);
    step();      expect_v("load_cell", F_CELL, 1);
    press(B_ST); expect_v("to_nav", F_ST, 3);
                 expect_v("nav_pc", F_PC, 1);
    press(B_LF); expect_v("wrap_left", F_PJ, 3);
    press(B_UP); expect_v("wrap_up", F_PI, 3);
    step();
    set_btn(B_RT, 1'b1);
    repeat (10) step();
    set_btn(B_RT, 1'b0);
    expect_v("hold_right", F_PJ, 0);
    press(B_DN); expect_v("wrap_down", F_PI, 0);
    press(B_RT); expect_v("right1", F_PJ, 1);
                 expect_v("vis_cell", F_CELL, 2);
    press(B_A);  expect_v("a_visible", F_ST, 3);
    press(B_RT); expect_v("hidden_cell", F_CELL, 0);
    press(B_A);  expect_v("to_enter", F_ST, 4);
    press(B_UP); expect_v("sel_up", F_SEL, 2);
    press(B_A);  expect_v("wrong_err", F_ERR, 1);
                 expect_v("wrong_str", F_STR, 1);
                 expect_v("wrong_st", F_ST, 4);
    step();      expect_v("err_pulse_end", F_ERR, 0);
    press(B_LF); expect_v("enter_nomove", F_PJ, 2);
    press(B_DN); expect_v("sel_dn", F_SEL, 1);
    press(B_DN); expect_v("sel_wrap_dn", F_SEL, 4);
    press(B_UP); expect_v("sel_wrap_up", F_SEL, 1);
    press(B_UP);
    press(B_B);  expect_v("b_back", F_ST, 3);
    press(B_A);  expect_v("re_enter", F_ST, 4);
                 expect_v("sel_kept", F_SEL, 2);
    press(B_A);  expect_v("strike2", F_STR, 2);
    press(B_A);  expect_v("strike3", F_STR, 3);
                 expect_v("strike3_err", F_ERR, 1);
                 expect_v("strike3_st", F_ST, 4);
    step();      expect_v("defeat", F_ST, 6);
                 expect_v("defeat_str", F_STR, 3);
    press(B_ST); expect_v("defeat_start", F_ST, 1);

    // Game 2: victory on last hidden cell
    bus.selected_visibility = 16'hFFF7;
    press(B_A);  expect_v("g2_load", F_ST, 2);
    press(B_ST); expect_v("g2_nav", F_ST, 3);
    press(B_LF); expect_v("g2_hidden", F_CELL, 0);
    press(B_A);  expect_v("g2_enter", F_ST, 4);
    repeat (3) press(B_UP);
    expect_v("g2_sel4", F_SEL, 4);
    press(B_A);  expect_v("g2_reveal", F_ST, 3);
                 expect_v("g2_cell", F_CELL, 4);
    step();      expect_v("victory", F_ST, 5);
    press(B_ST); expect_v("vic_start", F_ST, 1);
                 expect_v("vic_pc", F_PC, 0);

    // Game 3: hard timeout (limit 2)
    bus.selected_visibility = 16'hFFFB;
    press(B_UP); expect_v("g3_hard", F_DIF, 1);
    press(B_A);
    press(B_ST); expect_v("g3_nav", F_ST, 3);
                 expect_v("g3_el0", F_EL, 0);
    tick();      expect_v("g3_el1", F_EL, 1);
    tick();      expect_v("g3_el2", F_EL, 2);
                 expect_v("g3_still_nav", F_ST, 3);
    step();      expect_v("timeout", F_ST, 6);
    tick();      expect_v("defeat_tick", F_EL, 2);
    press(B_ST); expect_v("g3_start", F_ST, 1);

    // Game 4: pause, then reset mid-ENTER
    press(B_A);
    press(B_ST); expect_v("g4_nav", F_ST, 3);
`ifdef SUDOKU_PAUSE_EN
    press(B_ST); expect_v("pause", F_ST, 7);
                 expect_v("pause_pc", F_PC, 0);
    repeat (3) tick();
    expect_v("pause_el", F_EL, 0);
    press(B_UP); expect_v("pause_up", F_ST, 7);
                 expect_v("pause_pi", F_PI, 0);
    press(B_ST); expect_v("unpause", F_ST, 3);
`else
    press(B_ST); expect_v("nopause", F_ST, 3);
`endif
    press(B_RT);
    press(B_RT);
    press(B_A);  expect_v("g4_enter", F_ST, 4);
                 expect_v("g4_pj", F_PJ, 2);
    step();
    rst_n = 1'b0;
    #2;
    expect_reset("midrst");
    step();
    step();
    rst_n = 1'b1;
    press(B_ST); expect_v("post_rst_start", F_ST, 1);

    repeat (3) step();
    if (q.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/sudoku_game_fsm.md
# sudoku_game_fsm

Parametrised successor to the Sudoku game controller. It owns the game state machine, cursor, working board, strike counter and play timer in one block, sized by board side. It adds button edge detection, cursor wrap-around, a time-limited defeat and an optional pause. It sits between the debounced button front-end and the display/score logic.

## Interface
- `SIDE`, 9, board side; legal values 4, 9 (box = sqrt(SIDE))
- `VW`, 4, cell value width; must hold SIDE
- `MAX_STRIKES`, 3, wrong entries that cause defeat; 1..3
- `TIME_LIMIT`, 600, seconds allowed on easy; hard allows TIME_LIMIT/2
- `TW`, 11, elapsed-time counter width
- `clk`  in  1  system clock; the block has one clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `tick_1hz`  in  1  one-cycle pulse per second
- `up_button`, `down_button`, `left_button`, `right_button`, `start_button`, `a_button`, `b_button`  in  1 each  debounced level; press = rising edge, detected internally
- `selected_visibility`  in  SIDE*SIDE  puzzle mask, bit k = cell k given
- `selected_map`  in  SIDE*SIDE*VW  solution, cell k at [k*VW +: VW]
- `state`  out  3  current state code
- `pos_i`, `pos_j`  out  VW each  cursor row/column
- `cell_value`  out  VW  solution at cursor if visible, else 0
- `selected_number`  out  VW  candidate digit
- `strikes`  out  2  wrong-entry count
- `elapsed`  out  TW  seconds played
- `difficulty`  out  1  0 easy, 1 hard
- `playing_condition`  out  1  high in NAVIGATE or ENTER
- `error`  out  1  one-cycle pulse on wrong entry

## Operation
- States: IDLE 000, SELECT 001, LOAD 010, NAVIGATE 011, ENTER 100, VICTORY 101, DEFEAT 110, PAUSE 111.
- IDLE: start → SELECT.
- SELECT: up sets difficulty 1, down sets 0; a → LOAD.
- LOAD: every cycle copies the visibility mask and solution map into internal registers. Also sets pos 0,0, strikes 0, elapsed 0, selected_number 1. Start → NAVIGATE.
- NAVIGATE: up/down/left/right move the cursor with wrap (0↔SIDE-1). Priority up>down>left>right; one move per press. A on a hidden cell → ENTER; a on a visible cell is ignored.
- ENTER: up increments selected_number (SIDE wraps to 1); down decrements (1 wraps to SIDE). Direction buttons do not move the cursor.
  - A with a correct value: sets the visibility bit → NAVIGATE.
  - A with a wrong value: strikes+1, error pulse, stay in ENTER.
  - B → NAVIGATE, no change.
- VICTORY, DEFEAT: start → SELECT; board and strikes are held for display.
- Defeat: from NAVIGATE/ENTER (and PAUSE) when strikes==MAX_STRIKES or elapsed==limit.
- Victory: from NAVIGATE/ENTER when the visibility mask is all ones.
- Defeat has priority over victory, and both override button transitions.
- Elapsed counter: increments on tick_1hz only while playing_condition; saturates at limit.
- Index = pos_i*SIDE+pos_j; cell_value is combinational from registers.

## Timing
- Button edge detect: press is valid in the cycle where button=1 and previous sample=0. The resulting state/register update takes effect at that clock edge. A held button produces exactly one press.
- Reset values: state IDLE, pos 0/0, selected_number 1, strikes 0, elapsed 0, difficulty 0, error 0, visibility and board all 0, button history 0.
- Reset assertion mid-game returns to IDLE immediately, independent of clk.
- Wrong entry: error high for exactly one cycle, the cycle after the a-press edge. Strikes is updated on the same edge.
- Final correct reveal: VICTORY is entered one cycle after NAVIGATE is entered.
- Third strike: DEFEAT is entered one cycle after strikes reaches MAX_STRIKES; error still pulses.
- Tick and button press in the same cycle are both honoured.

## Configuration
- `SUDOKU_PAUSE_EN` defined:
  - start in NAVIGATE or ENTER → PAUSE; elapsed is frozen and playing_condition is 0.
  - start in PAUSE returns to the state it came from.
  - Only start is acted on in PAUSE.
- Macro undefined: code 111 is unreachable; start is ignored in NAVIGATE/ENTER.

## Test plan
- Reset: drive reset=0 mid-ENTER → all outputs at reset values the same cycle; after release, start press → state 001.
- Navigation wrap (SIDE=4): from 0/0, press left → pos_j=3; press up → pos_i=3; hold right 10 cycles → pos_j=0 (one move).
- Wrong entry: hidden cell with value 3, select 2, press a → error pulse 1 cycle, strikes=1, state stays 100. Third wrong a → state 110.
- Victory: mask with one hidden cell (value 4, SIDE=4); navigate, a, up×3, a → state 011, then 101; start → 001.
- Timeout: TIME_LIMIT=4, difficulty=1, 2 ticks in NAVIGATE → elapsed=2, state 110. A tick in SELECT leaves elapsed=0.
- Pause (macro on): in NAVIGATE, start → 111; 3 ticks → elapsed unchanged; start → 011. Macro off: start in NAVIGATE → stays 011.
